// File: rtl/lsu_mem_if.sv
// Load/store unit bridging the RV32i execute stage and a wait-state-capable
// data memory: one request in flight, byte-lane steering, sign/zero
// extension, and misaligned / illegal-size / timeout error reporting.
module lsu_mem_if #(
   parameter int unsigned XLEN    = 32,
   parameter int unsigned ADDR_W  = 32,
   parameter int unsigned TIMEOUT = 16,
   parameter int unsigned TO_W    = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic                req_store,
   input  logic [2:0]          req_funct3,
   input  logic [ADDR_W-1:0]   req_addr,
   input  logic [XLEN-1:0]     req_wdata,
   input  logic [4:0]          req_rd,
   output logic                rsp_valid,
   output logic [XLEN-1:0]     rsp_rdata,
   output logic [4:0]          rsp_rd,
   output logic                rsp_err,
   output logic [1:0]          rsp_err_code,
   output logic                mem_req,
   output logic                mem_we,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic [XLEN/8-1:0]   mem_be,
   output logic [XLEN-1:0]     mem_wdata,
   input  logic                mem_ack,
   input  logic [XLEN-1:0]     mem_rdata
);

   localparam int unsigned BE_W  = XLEN / 8;
   localparam int unsigned OFF_W = $clog2(BE_W);
   localparam int unsigned IDX_W = $clog2(XLEN);
   localparam logic [TO_W-1:0] TO_LAST = (TIMEOUT == 0) ? '0 : TO_W'(TIMEOUT - 1);

   localparam logic [1:0] CODE_NONE  = 2'd0;
   localparam logic [1:0] CODE_ALIGN = 2'd1;
   localparam logic [1:0] CODE_SIZE  = 2'd2;
   localparam logic [1:0] CODE_TIME  = 2'd3;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   state_t            state, state_next;

   logic              store_q;
   logic [2:0]        funct3_q;
   logic [ADDR_W-1:0] addr_q;
   logic [XLEN-1:0]   wdata_q;
   logic [4:0]        rd_q;
   logic [XLEN-1:0]   rdata_q;
   logic [1:0]        err_code_q;
   logic [TO_W-1:0]   to_cnt;

   logic [1:0]        chk_code;
   logic [2:0]        align_mask;
   logic [OFF_W-1:0]  off_q;
   logic              expire;

   logic [BE_W-1:0]   be_c;
   logic [XLEN-1:0]   wdata_c;
   logic [XLEN-1:0]   shifted;
   logic [XLEN-1:0]   load_ext;
   logic [IDX_W-1:0]  msb_idx;
   logic              sign_bit;
   int unsigned       nbytes;
   int unsigned       nbits;
   int unsigned       off_i;

   assign off_q  = addr_q[OFF_W-1:0];
   assign expire = (TIMEOUT != 0) && (to_cnt == TO_LAST);

   // Classify the incoming request; the result is latched on accept.
   always_comb begin
      chk_code   = CODE_NONE;
      align_mask = 3'b000;
      case (req_funct3[1:0])
         2'd0:    align_mask = 3'b000;
         2'd1:    align_mask = 3'b001;
         2'd2:    align_mask = 3'b011;
         default: align_mask = 3'b111;
      endcase
      if (((req_funct3[1:0] == 2'd3) && (XLEN != 64)) ||
          (req_funct3 == 3'b111) ||
          (req_funct3[2] && req_store)) begin
         chk_code = CODE_SIZE;
      end else if ((req_addr[2:0] & align_mask) != 3'b000) begin
         chk_code = CODE_ALIGN;
      end
   end

   // Byte enables and lane-steered write data for the latched request.
   always_comb begin
      nbytes = 32'd1 << funct3_q[1:0];
      if (nbytes > BE_W) nbytes = BE_W;
      off_i  = 32'(off_q);
      be_c   = '0;
      for (int unsigned i = 0; i < BE_W; i++) begin
         be_c[i] = (i >= off_i) && (i < off_i + nbytes);
      end
      wdata_c = wdata_q << {off_q, 3'b000};
   end

   // Pull the addressed bytes down to bit 0 and extend to XLEN.
   always_comb begin
      shifted = mem_rdata >> {off_q, 3'b000};
      nbits   = 32'd8 << funct3_q[1:0];
      if (nbits > XLEN) nbits = XLEN;
      msb_idx  = IDX_W'(nbits - 1);
      sign_bit = ~funct3_q[2] & shifted[msb_idx];
      load_ext = '0;
      for (int unsigned i = 0; i < XLEN; i++) begin
         load_ext[i] = (i < nbits) ? shifted[i] : sign_bit;
      end
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   // Next-state and output decode; memory and response buses are zero outside their state.
   always_comb begin
      state_next   = state;
      req_ready    = 1'b0;
      mem_req      = 1'b0;
      mem_we       = 1'b0;
      mem_addr     = '0;
      mem_be       = '0;
      mem_wdata    = '0;
      rsp_valid    = 1'b0;
      rsp_rdata    = '0;
      rsp_rd       = '0;
      rsp_err      = 1'b0;
      rsp_err_code = CODE_NONE;
      case (state)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               state_next = (chk_code == CODE_NONE) ? ACCESS : RESP;
            end
         end
         ACCESS: begin
            mem_req   = 1'b1;
            mem_we    = store_q;
            mem_addr  = {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
            mem_be    = be_c;
            mem_wdata = wdata_c;
            if (mem_ack || expire) state_next = RESP;
         end
         RESP: begin
            rsp_valid    = 1'b1;
            rsp_rdata    = rdata_q;
            rsp_rd       = rd_q;
            rsp_err      = (err_code_q != CODE_NONE);
            rsp_err_code = err_code_q;
            state_next   = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Request capture, timeout counting and response data; ack wins over an expiring counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         store_q    <= 1'b0;
         funct3_q   <= '0;
         addr_q     <= '0;
         wdata_q    <= '0;
         rd_q       <= '0;
         rdata_q    <= '0;
         err_code_q <= CODE_NONE;
         to_cnt     <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  store_q    <= req_store;
                  funct3_q   <= req_funct3;
                  addr_q     <= req_addr;
                  wdata_q    <= req_wdata;
                  rd_q       <= req_rd;
                  rdata_q    <= '0;
                  err_code_q <= chk_code;
                  to_cnt     <= '0;
               end
            end
            ACCESS: begin
               if (mem_ack) begin
                  rdata_q <= store_q ? '0 : load_ext;
               end else if (expire) begin
                  rdata_q    <= '0;
                  err_code_q <= CODE_TIME;
               end else begin
                  to_cnt <= to_cnt + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: doc/lsu_mem_if.md
Name: lsu_mem_if

Overview:
- Parametrised load/store unit between the RV32i core execute stage and the data memory.
- Accepts one load/store request at a time, handles byte/halfword/word (and doubleword when XLEN=64) access, byte-lane steering, byte enables and sign/zero extension.
- Drives a wait-state-capable memory handshake.
- Reports misaligned, illegal-size and timeout errors instead of silently corrupting data.

Parameters:
- XLEN, 32, data path width in bits; 32 or 64.
- ADDR_W, 32, byte address width.
- TIMEOUT, 16, maximum cycles to wait for mem_ack; 0 disables timeout.
- TO_W, 8, width of the timeout counter; must hold TIMEOUT.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- req_valid  in  1  core request valid.
- req_ready  out  1  unit can accept a request.
- req_store  in  1  1=store, 0=load.
- req_funct3  in  3  RISC-V funct3 (size in [1:0], unsigned in [2]).
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  XLEN  store data, LSB-aligned.
- req_rd  in  5  destination register tag, returned with response.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_rdata  out  XLEN  extended load data (0 for stores).
- rsp_rd  out  5  tag echoed from request.
- rsp_err  out  1  request failed.
- rsp_err_code  out  2  0=none, 1=misaligned, 2=illegal size, 3=timeout.
- mem_req  out  1  memory access strobe.
- mem_we  out  1  write enable.
- mem_addr  out  ADDR_W  lane-aligned address (low log2(XLEN/8) bits zero).
- mem_be  out  XLEN/8  byte enables.
- mem_wdata  out  XLEN  lane-steered write data.
- mem_ack  in  1  memory completes access this cycle.
- mem_rdata  in  XLEN  read data, valid with mem_ack.

Behaviour:
- Reset:
  - rst=1 at a rising edge forces state IDLE.
  - All outputs go to 0, except req_ready=1.
  - The timeout counter is cleared.
  - Reset mid-access drops mem_req the next cycle and produces no response.
- FSM states IDLE, ACCESS, RESP:
  - IDLE: req_ready=1. On req_valid, latch store, funct3, addr, wdata, rd.
    - Error check passes -> ACCESS.
    - Error check fails -> RESP with err.
  - ACCESS: mem_req=1, with mem_we/mem_addr/mem_be/mem_wdata held stable every cycle until mem_ack.
    - On mem_ack, latch mem_rdata and go to RESP.
  - RESP: rsp_valid=1 for exactly one cycle, then IDLE. There is no response backpressure.
- Error checks, evaluated on latched request:
  - 2^size > XLEN/8, or funct3 = 3'b111, or funct3[2]=1 with a store -> code 2.
  - Otherwise addr mod 2^size != 0 -> code 1.
  - Errored requests never assert mem_req.
- Latency:
  - Accept at edge N.
  - mem_req high in cycle N+1.
  - With ack in the same cycle, rsp_valid is high in cycle N+2.
  - Each wait state adds one cycle.
- Lane steering:
  - off = addr[log2(XLEN/8)-1:0].
  - mem_be = ((1<<2^size)-1) << off.
  - mem_wdata = wdata << (8*off); unused lanes are don't-care but driven 0.
  - Loads: the 2^size bytes are taken from mem_rdata >> (8*off), then sign-extended (funct3[2]=0) or zero-extended (funct3[2]=1) to XLEN.
- Timeout:
  - The counter increments each ACCESS cycle without ack.
  - When the counter equals TIMEOUT-1 with no ack (i.e. TIMEOUT cycles elapsed), go to RESP with code 3 and rsp_rdata=0. mem_req deasserts next cycle.
  - A late mem_ack arriving in IDLE is ignored.
  - An ack on the same cycle the counter expires takes priority: normal completion.
  - The counter clears on entering ACCESS.
- Store responses: rsp_valid is still pulsed (rsp_rdata=0) so the core can retire in order.
- req_ready=0 in ACCESS and RESP. A req_valid asserted there is not consumed and must be held by the core.

Test Plan:
- LB, addr=0x0000_0003, mem word 0x80FF_1234 at 0x0, ack same cycle -> mem_be=4'b1000, rsp_rdata=0xFFFF_FF80, rsp_valid 2 cycles after accept, rsp_err=0.
- LHU, addr=0x2, same word -> mem_be=4'b1100, rsp_rdata=0x0000_80FF; LH gives 0xFFFF_80FF.
- SB, addr=0x5, wdata=0xAB -> mem_addr=0x4, mem_be=4'b0010, mem_wdata=0x0000_AB00, mem_we=1; a readback word load returns 0x....AB.. with other bytes unchanged.
- LW, addr=0x6 -> rsp_err=1, code 1, one cycle after accept, mem_req never asserted. SD with funct3=011 at XLEN=32 -> code 2.
- LW with mem_ack delayed 3 cycles -> mem_req high 4 consecutive cycles with stable address, rsp_valid 5 cycles after accept, req_ready low throughout.
- TIMEOUT=16, no ack -> mem_req high 16 cycles, rsp_err code 3, rsp_rdata=0. A later ack is ignored. rst asserted during a second access -> mem_req low next cycle, no rsp_valid, req_ready=1.
